// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between the parking controller and the
// bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         underflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, underflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, underflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b, LSB first, one bit per clock.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero when the result underflows.
//
// state | meaning
// IDLE  | waiting for start; diff/underflow hold the last result
// SHIFT | one result bit per cycle, N cycles
// DONE  | publish diff/underflow, pulse done, return to IDLE
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          shift_en;
    logic          finish;

    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  res;
    logic [CW-1:0] cnt;
    logic          borrow;
    logic          d;
    logic          borrow_nxt;

    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  diff_q;
    logic          underflow_q;

    assign d          = sa[0] ^ sb[0] ^ borrow;
    assign borrow_nxt = (~sa[0] & sb[0]) | (~sa[0] & borrow) | (sb[0] & borrow);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa          <= '0;
            sb          <= '0;
            res         <= '0;
            cnt         <= '0;
            borrow      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            diff_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == SHIFT);
            done_q <= finish;
            if (load) begin
                sa     <= bus.a;
                sb     <= bus.b;
                borrow <= 1'b0;
                cnt    <= '0;
            end
            if (shift_en) begin
                res    <= {d, res[N-1:1]};
                sa     <= {1'b0, sa[N-1:1]};
                sb     <= {1'b0, sb[N-1:1]};
                borrow <= borrow_nxt;
                cnt    <= cnt + 1'b1;
            end
            // Results update only here, so downstream compares never see a partial value.
            if (finish) begin
`ifdef SERIAL_SUB_SAT_EN
                diff_q <= borrow ? '0 : res;
`else
                diff_q <= res;
`endif
                underflow_q <= borrow;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.diff      = diff_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (N = 8), covers both
// SERIAL_SUB_SAT_EN builds.
module tb_serial_subtractor;
    localparam int N = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] dwrap;
        logic       uf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [7:0] prev_d;
    logic       prev_u;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] exp_diff(input vec_t v);
`ifdef SERIAL_SUB_SAT_EN
        return v.uf ? 8'd0 : v.dwrap;
`else
        return v.dwrap;
`endif
    endfunction

    // One operation: start for one cycle, observe N+2 edges, leave the DUT in IDLE.
    task automatic run_op(input vec_t v, input string tag);
        int busy_cnt;
        int busy_wrong;
        int early_done;
        int held_bad;
        logic [7:0] ed;
        busy_cnt   = 0;
        busy_wrong = 0;
        early_done = 0;
        held_bad   = 0;
        ed         = exp_diff(v);
        bus.start  = 1'b1;
        bus.a      = v.a;
        bus.b      = v.b;
        for (int j = 0; j <= N + 1; j++) begin
            tick();
            if (j == 0) bus.start = 1'b0;
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            if (bus.busy) busy_cnt++;
            if (bus.busy != (j < N)) busy_wrong++;
            if (j < N + 1) begin
                if (bus.done) early_done++;
                if (bus.diff != prev_d || bus.underflow != prev_u) held_bad++;
            end else begin
                check({tag, "_done"}, int'(bus.done), 1);
                check({tag, "_diff"}, int'(bus.diff), int'(ed));
                check({tag, "_uf"}, int'(bus.underflow), int'(v.uf));
            end
        end
        check({tag, "_busy_cycles"}, busy_cnt, N);
        check({tag, "_busy_window"}, busy_wrong, 0);
        check({tag, "_early_done"}, early_done, 0);
        check({tag, "_held"}, held_bad, 0);
        prev_d = ed;
        prev_u = v.uf;
    endtask

    vec_t vecs[12];
    vec_t hv[3];

    initial begin
        int bad;
        int early;

        vecs[0]  = '{8'd200, 8'd57,  8'd143, 1'b0};
        vecs[1]  = '{8'd128, 8'd1,   8'd127, 1'b0};
        vecs[2]  = '{8'd255, 8'd255, 8'd0,   1'b0};
        vecs[3]  = '{8'd5,   8'd9,   8'd252, 1'b1};
        vecs[4]  = '{8'd0,   8'd1,   8'd255, 1'b1};
        vecs[5]  = '{8'd100, 8'd100, 8'd0,   1'b0};
        vecs[6]  = '{8'd1,   8'd0,   8'd1,   1'b0};
        vecs[7]  = '{8'd37,  8'd200, 8'd93,  1'b1};
        vecs[8]  = '{8'd255, 8'd0,   8'd255, 1'b0};
        vecs[9]  = '{8'd64,  8'd128, 8'd192, 1'b1};
        vecs[10] = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[11] = '{8'd170, 8'd85,  8'd85,  1'b0};

        hv[0] = '{8'd50, 8'd20, 8'd30,  1'b0};
        hv[1] = '{8'd3,  8'd4,  8'd255, 1'b1};
        hv[2] = '{8'd77, 8'd77, 8'd0,   1'b0};

        n_pass    = 0;
        n_total   = 0;
        prev_d    = 8'd0;
        prev_u    = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        tick();
        tick();
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy || bus.done || bus.diff != 8'd0 || bus.underflow) bad++;
        end
        check("reset_idle_quiet", bad, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high with operands changing every cycle
        bus.start = 1'b1;
        bus.a     = hv[0].a;
        bus.b     = hv[0].b;
        for (int op = 0; op < 3; op++) begin
            early = 0;
            for (int j = 0; j <= N + 1; j++) begin
                tick();
                if (j < N + 1) begin
                    if (bus.done) early++;
                    bus.a = 8'($urandom);
                    bus.b = 8'($urandom);
                end else begin
                    check($sformatf("held%0d_done", op), int'(bus.done), 1);
                    check($sformatf("held%0d_diff", op), int'(bus.diff), int'(exp_diff(hv[op])));
                    check($sformatf("held%0d_uf", op), int'(bus.underflow), int'(hv[op].uf));
                    if (op < 2) begin
                        bus.a = hv[op + 1].a;
                        bus.b = hv[op + 1].b;
                    end else begin
                        bus.start = 1'b0;
                    end
                end
            end
            check($sformatf("held%0d_early_done", op), early, 0);
        end
        prev_d = exp_diff(hv[2]);
        prev_u = hv[2].uf;

        // reset during the 4th SHIFT cycle abandons the operation
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd57;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_done", int'(bus.done), 0);
        check("rst_mid_diff", int'(bus.diff), 0);
        check("rst_mid_uf", int'(bus.underflow), 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) bad++;
        end
        check("rst_mid_no_done", bad, 0);
        prev_d = 8'd0;
        prev_u = 1'b0;
        run_op('{8'd10, 8'd3, 8'd7, 1'b0}, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
